// File: rtl/display_7seg_mux.sv
// Four-digit common-anode 7-segment driver: decimal count on the two right digits,
// count direction on the left digit, with per-slot anode blanking and per-frame input latching.
module display_7seg_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int GHOST_CYC   = 2,
  parameter int BLANK_LEAD  = 1
) (
  input  logic       clkNexys2,
  input  logic       Reset,
  input  logic [3:0] Contador,
  input  logic       Direccion,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] SLOT_ONES  = 2'd0;
  localparam logic [1:0] SLOT_TENS  = 2'd1;
  localparam logic [1:0] SLOT_BLANK = 2'd2;
  localparam logic [1:0] SLOT_DIR   = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       val_q, val_d;
  logic             dir_q, dir_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q;

  logic       slot_last;
  logic       frame_wrap;
  logic       ghost;
  logic       tens;
  logic [3:0] ones;
  logic [6:0] seg_sel;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] code;
    code = SEG_BLANK;
    case (d)
      4'd0: code = 7'b1000000;
      4'd1: code = 7'b1111001;
      4'd2: code = 7'b0100100;
      4'd3: code = 7'b0110000;
      4'd4: code = 7'b0011001;
      4'd5: code = 7'b0010010;
      4'd6: code = 7'b0000010;
      4'd7: code = 7'b1111000;
      4'd8: code = 7'b0000000;
      4'd9: code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  always_comb begin
    slot_last     = (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_wrap    = slot_last && (idx_q == SLOT_DIR);
    refresh_cnt_d = slot_last ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = slot_last ? idx_q + 2'd1 : idx_q;
    // Inputs are sampled only at the frame boundary so one frame never mixes two counts.
    val_d         = frame_wrap ? Contador  : val_q;
    dir_d         = frame_wrap ? Direccion : dir_q;

    tens = (val_q >= 4'd10);
    ones = tens ? (val_q - 4'd10) : val_q;

    seg_sel = SEG_BLANK;
    case (idx_q)
      SLOT_ONES:  seg_sel = digit_code(ones);
      SLOT_TENS:  seg_sel = (!tens && (BLANK_LEAD == 1)) ? SEG_BLANK : digit_code({3'b000, tens});
      SLOT_BLANK: seg_sel = SEG_BLANK;
      SLOT_DIR:   seg_sel = dir_q ? SEG_D : SEG_U;
      default:    seg_sel = SEG_BLANK;
    endcase

    ghost = (GHOST_CYC > 0) && (32'(refresh_cnt_q) < 32'(GHOST_CYC));
    an_d  = ghost ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = ghost ? SEG_BLANK : seg_sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkNexys2) begin
    if (Reset) begin
      refresh_cnt_q <= '0;
      idx_q         <= SLOT_ONES;
      val_q         <= 4'd0;
      dir_q         <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      val_q         <= val_d;
      dir_q         <= dir_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
